// File: rtl/mio_bus_slave_if.sv
// CPU-side memory/IO bus: request, direction, address and data from the CPU;
// read data and completion strobe back from the responder.
interface mio_bus_slave_if;
    logic        CPU_MIO;
    logic        mem_w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        MIO_ready;

    // Handshake: the CPU holds CPU_MIO/mem_w/addr/wdata until the responder
    // samples them in IDLE; MIO_ready is a single-cycle completion pulse, and
    // rdata is valid from that pulse until the next read completes.
    modport master (output CPU_MIO, mem_w, addr, wdata, input rdata, MIO_ready);
    modport slave  (input CPU_MIO, mem_w, addr, wdata, output rdata, MIO_ready);
endinterface

// File: rtl/mio_bus_slave.sv
// Bus responder: word RAM with configurable wait states, an LED/switch
// register at 0xF000_0000 and a free-running cycle counter at 0xF000_0004.
module mio_bus_slave #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2,
    parameter int IO_W        = 16
) (
    input  logic            clk,
    input  logic            reset,
    mio_bus_slave_if.slave  bus,
    input  logic [IO_W-1:0] sw,
    output logic [IO_W-1:0] led,
    output logic [1:0]      dbg_state_o
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_e;

    localparam int WCW = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

    state_e            state_q;
    logic [WCW-1:0]    wcnt_q;
    logic [31:2]       addr_q;
    logic [31:0]       wdata_q;
    logic              wr_q;
    logic [31:0]       rdata_q;
    logic [31:0]       cnt_q;
    logic [IO_W-1:0]   led_q;
    logic              ready_q;
    logic [31:0]       mem_q [2**ADDR_W];

    logic              access_d;
    logic              periph_d;
    logic              sel_led_d;
    logic              sel_cnt_d;
    logic [ADDR_W-1:0] ram_idx_d;
    logic [31:0]       rd_val_d;
    logic [31:0]       cnt_d;
    logic              ram_we_d;

    always_comb begin
        access_d  = (state_q == S_WAIT) && (wcnt_q == '0);
        periph_d  = (addr_q[31:28] == 4'hF);
        sel_led_d = periph_d && (addr_q[27:2] == 26'd0);
        sel_cnt_d = periph_d && (addr_q[27:2] == 26'd1);
        ram_idx_d = addr_q[ADDR_W+1:2];
        ram_we_d  = access_d && wr_q && !periph_d && !reset;
        rd_val_d  = 32'd0;
        if (!periph_d)
            rd_val_d = mem_q[ram_idx_d];
        else if (sel_led_d)
            rd_val_d = 32'(sw);
        else if (sel_cnt_d)
            rd_val_d = cnt_q;
        // A counter write replaces that edge's increment.
        cnt_d = (access_d && wr_q && sel_cnt_d) ? wdata_q : cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (ram_we_d)
            mem_q[ram_idx_d] <= wdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            ready_q <= 1'b0;
            rdata_q <= 32'd0;
            led_q   <= '0;
            cnt_q   <= 32'd0;
        end else begin
            cnt_q   <= cnt_d;
            ready_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.CPU_MIO) begin
                        addr_q  <= bus.addr[31:2];
                        wdata_q <= bus.wdata;
                        wr_q    <= bus.mem_w;
                        wcnt_q  <= WCW'(WAIT_CYCLES);
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wcnt_q != '0) begin
                        wcnt_q <= wcnt_q - WCW'(1);
                    end else begin
                        if (wr_q) begin
                            if (sel_led_d)
                                led_q <= wdata_q[IO_W-1:0];
                        end else begin
                            rdata_q <= rd_val_d;
                        end
                        ready_q <= 1'b1;
                        state_q <= S_ACK;
                    end
                end
                S_ACK:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.rdata     = rdata_q;
    assign bus.MIO_ready = ready_q;
    assign led           = led_q;
    assign dbg_state_o   = state_q;
endmodule
